// File: rtl/dac_pkg.sv
// dac_pkg: shared constants, FSM state type and frame builder for the
// LTC2624 SPI transmitter (dac).
package dac_pkg;

  localparam int         FRAME_BITS       = 32;
  localparam logic [3:0] CMD_WRITE_UPDATE = 4'b0011;
  localparam logic [3:0] ADDR_ALL         = 4'b1111;
  localparam logic [11:0] CODE_FULL       = 12'hFFF;
  localparam logic [11:0] CODE_HALF       = 12'h800;

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, HOLD, GAP} dac_state_t;

  // 8 don't-care bits, command, address, 12-bit code, 4 don't-care bits.
  function automatic logic [FRAME_BITS-1:0] make_frame(input logic mid);
    return {8'h00, CMD_WRITE_UPDATE, ADDR_ALL, (mid ? CODE_HALF : CODE_FULL), 4'h0};
  endfunction

endpackage

// File: rtl/dac_sck_gen.sv
// dac_sck_gen: SCK half-period counter. While en is high it alternates
// low and high phases of CLK_DIV cycles each, starting with a low phase,
// and pulses rise/fall on the last cycle of the low/high phase so the
// caller can register the SCK edge on the following clock.
//   clock_in : system clock
//   rst_n    : async active-low reset
//   en       : run the counter; low holds it at the start of a low phase
//   rise     : strobe, SCK should go high on the next edge
//   fall     : strobe, SCK should go low on the next edge
module dac_sck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clock_in,
  input  logic rst_n,
  input  logic en,
  output logic rise,
  output logic fall
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          phase;   // 0 = low phase, 1 = high phase
  logic          tc;

  assign tc = (cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clock_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (!en) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (tc) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + 1'b1;
    end
  end

  assign rise = en & tc & ~phase;
  assign fall = en & tc &  phase;

endmodule

// File: rtl/dac.sv
// dac: SPI transmitter for the LTC2624 quad DAC. Each rising edge of start
// (accepted only in IDLE with the clear released) sends one 32-bit
// write-and-update frame to all four channels, code full- or mid-scale.
//   clock_in : system clock
//   rst_n    : async active-low reset
//   start    : level input, each rising edge requests a frame
//   half     : 1 = code 12'h800, 0 = code 12'hFFF (latched at accept)
//   select   : DAC chip select, active-low
//   clock    : SPI SCK, idles low
//   MOSI     : serial data, MSB first, changes on SCK fall
//   reset    : DAC_CLR, active-low
// Build option: define DAC_CLR_PULSE_EN to hold reset low for CLR_CYCLES
// cycles after rst_n release; otherwise it rises on the first clock.
module dac
  import dac_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int CLR_CYCLES = 16
) (
  input  logic clock_in,
  input  logic rst_n,
  input  logic start,
  input  logic half,
  output logic select,
  output logic clock,
  output logic MOSI,
  output logic reset
);

  localparam int WW = $clog2(CLK_DIV + 1);

  dac_state_t            state;
  logic                  start_q;
  logic                  half_q;
  logic [FRAME_BITS-2:0] sreg;      // bits still to send after MOSI
  logic [5:0]            bit_cnt;
  logic [WW-1:0]         wait_cnt;  // HOLD / GAP duration
  logic                  rise, fall;
  logic                  accept, wait_tc;
  logic [FRAME_BITS-1:0] frame;

  assign accept  = start & ~start_q & reset & (state == IDLE);
  assign wait_tc = (wait_cnt == WW'(CLK_DIV - 1));
  assign frame   = make_frame(half_q);

  dac_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck (
    .clock_in (clock_in),
    .rst_n    (rst_n),
    .en       (state == SHIFT),
    .rise     (rise),
    .fall     (fall)
  );

`ifdef DAC_CLR_PULSE_EN
  localparam int CCW = $clog2(CLR_CYCLES + 1);
  logic [CCW-1:0] clr_cnt;

  always_ff @(posedge clock_in or negedge rst_n) begin
    if (!rst_n) begin
      clr_cnt <= '0;
      reset   <= 1'b0;
    end else if (!reset) begin
      if (clr_cnt == CCW'(CLR_CYCLES - 1)) reset <= 1'b1;
      else                                 clr_cnt <= clr_cnt + 1'b1;
    end
  end
`else
  always_ff @(posedge clock_in or negedge rst_n) begin
    if (!rst_n) reset <= 1'b0;
    else        reset <= 1'b1;
  end
`endif

  always_ff @(posedge clock_in or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      start_q  <= 1'b0;
      half_q   <= 1'b0;
      sreg     <= '0;
      bit_cnt  <= '0;
      wait_cnt <= '0;
      select   <= 1'b1;
      clock    <= 1'b0;
      MOSI     <= 1'b0;
    end else begin
      start_q <= start;
      case (state)
        IDLE: if (accept) begin
          half_q <= half;
          state  <= LOAD;
        end
        LOAD: begin
          sreg    <= frame[FRAME_BITS-2:0];
          MOSI    <= frame[FRAME_BITS-1];
          select  <= 1'b0;
          bit_cnt <= '0;
          state   <= SHIFT;
        end
        SHIFT: begin
          if (rise) begin
            clock <= 1'b1;
          end else if (fall) begin
            clock <= 1'b0;
            if (bit_cnt == 6'd31) begin
              bit_cnt  <= '0;
              MOSI     <= 1'b0;
              wait_cnt <= '0;
              state    <= HOLD;
            end else begin
              bit_cnt <= bit_cnt + 6'd1;
              MOSI    <= sreg[FRAME_BITS-2];
              sreg    <= {sreg[FRAME_BITS-3:0], 1'b0};
            end
          end
        end
        HOLD: begin
          if (wait_tc) begin
            wait_cnt <= '0;
            select   <= 1'b1;
            state    <= GAP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        GAP: begin
          if (wait_tc) begin
            wait_cnt <= '0;
            state    <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac.sv
// tb_dac: directed + randomized bench for dac. A negedge monitor decodes
// each select-low window into the captured word, SCK rise count and
// length; the initial block compares these with frames built from the
// field layout.
module tb_dac;

  localparam int CLK_DIV = 2;

  logic clock_in, rst_n, start, half;
  logic select, clock, MOSI, reset;

  int n_assert = 0;
  int n_fail   = 0;

  dac #(.CLK_DIV(CLK_DIV), .CLR_CYCLES(16)) dut (
    .clock_in (clock_in),
    .rst_n    (rst_n),
    .start    (start),
    .half     (half),
    .select   (select),
    .clock    (clock),
    .MOSI     (MOSI),
    .reset    (reset)
  );

  initial begin
    clock_in = 1'b0;
    forever #5 clock_in = ~clock_in;
  end

  // ---- monitor ----
  int          frames = 0, last_rises = 0, last_len = 0;
  int          cur_rises = 0, cur_len = 0, tot_rises = 0;
  logic [31:0] cap = '0, last_word = '0;
  logic        clk_prev = 1'b0, sel_prev = 1'b1;

  always @(negedge clock_in) begin
    if (clock === 1'b1 && clk_prev === 1'b0) tot_rises++;
    if (select === 1'b0) begin
      cur_len++;
      if (clock === 1'b1 && clk_prev === 1'b0) begin
        cur_rises++;
        cap = {cap[30:0], MOSI};
      end
    end else if (sel_prev === 1'b0) begin
      frames++;
      last_word  = cap;
      last_rises = cur_rises;
      last_len   = cur_len;
      cur_rises  = 0;
      cur_len    = 0;
    end
    clk_prev = clock;
    sel_prev = select;
  end

  // ---- reference model: frame from its fields ----
  function automatic logic [31:0] ref_frame(input logic h);
    logic [11:0] code;
    code = h ? 12'h800 : 12'hFFF;
    return {8'h00, 4'b0011, 4'b1111, code, 4'h0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(posedge clock_in); #1 start = 1'b1;
    @(posedge clock_in); #1 start = 1'b0;
  endtask

  task automatic wait_frame(input int budget);
    int f0;
    f0 = frames;
    for (int k = 0; k < budget && frames == f0; k++) @(posedge clock_in);
    check("frame_timeout", 32'(frames != f0), 32'd1);
  endtask

  initial begin
    int sel_k, clk_k, f0, t0, h;
    rst_n = 1'b0; start = 1'b0; half = 1'b0;

    // reset state
    repeat (4) @(negedge clock_in);
    check("rst_select", 32'(select), 32'd1);
    check("rst_clock",  32'(clock),  32'd0);
    check("rst_mosi",   32'(MOSI),   32'd0);
    check("rst_reset",  32'(reset),  32'd0);

    @(negedge clock_in) rst_n = 1'b1;
`ifdef DAC_CLR_PULSE_EN
    for (int k = 1; k <= 16; k++) begin
      @(posedge clock_in); #1;
      if (k == 5) start = 1'b1;
      if (k == 8) start = 1'b0;
      if (k == 15) check("clr_low_15", 32'(reset), 32'd0);
      if (k == 16) check("clr_high_16", 32'(reset), 32'd1);
    end
    repeat (200) @(posedge clock_in);
    check("clr_window_no_frame", 32'(frames), 32'd0);
    check("clr_window_no_sck", 32'(tot_rises), 32'd0);
`else
    @(posedge clock_in); #1;
    check("clr_release", 32'(reset), 32'd1);
    repeat (3) @(posedge clock_in);
`endif

    // frame A: half=0, start held 20 cycles, latency check
    half = 1'b0;
    f0 = frames;
    @(posedge clock_in); #1 start = 1'b1;
    sel_k = 0; clk_k = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clock_in); #1;
      if (select === 1'b0 && sel_k == 0) sel_k = k;
      if (clock === 1'b1 && clk_k == 0) clk_k = k;
    end
    check("lat_select", 32'(sel_k), 32'd2);
    check("lat_sck",    32'(clk_k), 32'(2 + CLK_DIV));
    repeat (12) @(posedge clock_in);
    #1 start = 1'b0;
    wait_frame(300);
    check("A_word",  last_word, ref_frame(1'b0));
    check("A_rises", 32'(last_rises), 32'd32);
    check("A_len",   32'(last_len), 32'(32 * 4 * CLK_DIV / 2 + CLK_DIV));
    repeat (60) @(posedge clock_in);
    check("A_one_frame", 32'(frames - f0), 32'd1);

    // random frames, half toggled mid-frame
    for (int i = 0; i < 4; i++) begin
      h = int'($urandom_range(0, 1));
      half = h[0];
      pulse_start();
      repeat (60) @(posedge clock_in);
      half = ~half;
      wait_frame(300);
      check("R_word",  last_word, ref_frame(h[0]));
      check("R_rises", 32'(last_rises), 32'd32);
      check("R_len",   32'(last_len), 32'd130);
      repeat (10) @(posedge clock_in);
    end

    // second edge during SHIFT is dropped
    half = 1'b1;
    f0 = frames; t0 = tot_rises;
    pulse_start();
    repeat (40) @(posedge clock_in);
    pulse_start();
    wait_frame(300);
    repeat (150) @(posedge clock_in);
    check("drop_frames", 32'(frames - f0), 32'd1);
    check("drop_rises",  32'(tot_rises - t0), 32'd32);
    half = 1'b0;
    pulse_start();
    wait_frame(300);
    check("B2_word",  last_word, ref_frame(1'b0));
    check("B2_rises", 32'(last_rises), 32'd32);

    // abort at bit 10
    repeat (10) @(posedge clock_in);
    pulse_start();
    for (int k = 0; k < 200 && cur_rises < 10; k++) @(posedge clock_in);
    check("abort_reach_bit10", 32'(cur_rises >= 10), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("abort_select", 32'(select), 32'd1);
    check("abort_clock",  32'(clock),  32'd0);
    check("abort_mosi",   32'(MOSI),   32'd0);
    repeat (3) @(posedge clock_in);
    @(negedge clock_in) rst_n = 1'b1;
    @(negedge clock_in);
    t0 = tot_rises;
    repeat (200) @(posedge clock_in);
    #1;
    check("abort_no_sck",   32'(tot_rises - t0), 32'd0);
    check("abort_idle_sel", 32'(select), 32'd1);

    // recovery after abort
    repeat (20) @(posedge clock_in);
    half = 1'b1;
    pulse_start();
    wait_frame(300);
    check("post_word",  last_word, ref_frame(1'b1));
    check("post_rises", 32'(last_rises), 32'd32);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dac.md
# dac

SPI transmitter for the LTC2624 quad 12-bit DAC on the Spartan-3E board. A rising edge on `start` sends one 32-bit "write and update" frame addressing all four DAC channels. The 12-bit code is full-scale or mid-scale, as selected by `half`. The block sits between the control logic and the board's DAC_CS, SPI_SCK, SPI_MOSI and DAC_CLR pins.

## Interface
Parameters:
- `CLK_DIV`, default 2: SCK half-period, counted in `clock_in` cycles (≥1). The default gives 25 MHz SCK from 100 MHz.
- `CLR_CYCLES`, default 16: length of the DAC_CLR pulse, used only when `DAC_CLR_PULSE_EN` is defined.

Ports:
- `clock_in`  in  1: system clock; every flop is clocked on its rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `start`  in  1: level input. Each rising edge requests one frame.
- `half`  in  1: 1 selects data 12'h800 (mid-scale); 0 selects 12'hFFF (full-scale).
- `select`  out  1: DAC chip select, active-low.
- `clock`  out  1: SPI SCK. Idle level is low.
- `MOSI`  out  1: serial data, MSB first.
- `reset`  out  1: DAC_CLR, active-low clear to the DAC.

## Operation
- Frame layout, 32 bits, MSB first:
  - 8'h00 (don't care)
  - command 4'b0011 (write and update)
  - address 4'b1111 (all DACs)
  - 12-bit data
  - 4'h0 (don't care)
- Full frame for `half`=1 is 32'h003F_8000. For `half`=0 it is 32'h003F_FFF0.
- `start` is registered once. A rising edge is detected as `start` & ~`start_q`.
- The edge is honoured only in IDLE, and only when `reset` output is high. An edge arriving in any other state is discarded, not queued.
- `half` is latched on the detect cycle. Changing `half` mid-frame has no effect on the frame in progress.
- FSM states:
  - IDLE → LOAD on an accepted edge.
  - LOAD: load the shift register, drive `select` low, put bit 31 on `MOSI`. Go to SHIFT.
  - SHIFT: 32 SCK periods. Each period is `CLK_DIV` cycles with `clock` low, then `CLK_DIV` cycles with `clock` high. `MOSI` advances to the next bit on the cycle `clock` falls. After the 32nd high phase, `clock` returns low. Go to HOLD.
  - HOLD: `clock` low and `select` still low for `CLK_DIV` cycles. Then `select` goes high. Go to GAP.
  - GAP: `select` high for `CLK_DIV` cycles (minimum CS-high time). Go to IDLE.
- Bit counter width: 6 bits. Terminal count is 31.

## Timing
- Reset values, for all outputs while `rst_n`=0: `select`=1, `clock`=0, `MOSI`=0, `reset`=0. FSM is in IDLE.
- All outputs are registered (no combinational paths from inputs).
- `start` rising at edge N: `select` falls at edge N+2. First `clock` rise is at N+2+`CLK_DIV`.
- Frame length, with `CLK_DIV`=2:
  - `select` low for 32·4+2 = 130 cycles.
  - Next frame can be accepted 134 cycles after the `start` edge.
- Data is stable for `CLK_DIV` cycles before each SCK rise and for `CLK_DIV` cycles after it.
- `rst_n` asserted mid-frame aborts immediately: outputs take their reset values. No partial frame is resumed after release.

## Configuration
- `DAC_CLR_PULSE_EN` defined: after `rst_n` deasserts, `reset` stays low for `CLR_CYCLES` cycles, then goes high. `start` edges during this window are ignored.
- `DAC_CLR_PULSE_EN` undefined: `reset` goes high on the first `clock_in` edge after `rst_n` deasserts. `start` is accepted from then on.

## Structure
- Package `dac_pkg`:
  - `FRAME_BITS`=32
  - `CMD_WRITE_UPDATE`=4'b0011
  - `ADDR_ALL`=4'b1111
  - `CODE_FULL`=12'hFFF
  - `CODE_HALF`=12'h800
  - state enum `dac_state_t` = {IDLE, LOAD, SHIFT, HOLD, GAP}
- One sub-module, `dac_sck_gen`: a half-period counter that produces SCK rise/fall strobes from `CLK_DIV`. The top level holds the FSM, the shift register, the bit counter, and the clear logic.

## Test plan
- Reset, `DAC_CLR_PULSE_EN` undefined: hold `rst_n`=0 → `select`=1, `clock`=0, `MOSI`=0, `reset`=0. Release → `reset`=1 one cycle later.
- `half`=0, `start` high for 20 cycles → exactly one frame. Sampling `MOSI` on 32 `clock` rises gives 32'h003F_FFF0. `select` is low 130 cycles.
- `half`=1, `start` pulse → 32'h003F_8000. Toggling `half` mid-frame does not change the captured word.
- Second `start` edge arriving during SHIFT → ignored. A later edge after GAP → a second full frame, with no more than 32 `clock` rises per `select`-low window.
- `rst_n` pulsed low at bit 10 → `select`=1 and `clock`=0 immediately. No further `clock` edges until a new `start`.
- `DAC_CLR_PULSE_EN` defined: `reset` stays low for 16 cycles after `rst_n` release. A `start` in that window produces no frame.
